// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters.
// A grant is held for a whole packet, and each byte is paced through the tx_start/tx_busy handshake.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clr,
  output logic [15:0]          byte_count
);

  localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    cnt;
  logic                lock;
  logic                last_q;

  logic [2*NUM_REQ-1:0] rot_valid;
  logic                 any_valid;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      next_id;
  logic                 gnt_valid;
  logic                 gnt_last;
  logic [7:0]           gnt_data;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // The valid vector is rotated so that bit 0 is the requester at the round-robin pointer.
  assign rot_valid = {req_valid, req_valid} >> rr_ptr;
  assign next_id   = wrap_add(grant_id, 1);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    any_valid = 1'b0;
    winner    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_valid && rot_valid[k]) begin
        any_valid = 1'b1;
        winner    = wrap_add(rr_ptr, k);
      end
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        gnt_valid    = req_valid[k];
        gnt_last     = req_last[k];
        gnt_data     = req_data[8*k +: 8];
        req_ready[k] = (state == ACCEPT);
      end
    end
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      lock        <= 1'b0;
      last_q      <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      byte_count  <= '0;
    end else begin
      tx_start <= 1'b0;
      // A timeout set lower down overrides this clear in the same cycle.
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            cnt      <= '0;
            state    <= ACCEPT;
          end
        end

        ACCEPT: begin
          if (gnt_valid) begin
            tx_data  <= gnt_data;
            last_q   <= gnt_last;
            lock     <= 1'b1;
            tx_start <= 1'b1;
            state    <= START;
          end else if (lock) begin
            if (cnt == CNT_MAX) begin
              lock   <= 1'b0;
              rr_ptr <= next_id;
              state  <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_MAX) begin
            timeout_err <= 1'b1;
            lock        <= 1'b0;
            rr_ptr      <= next_id;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_DONE: begin
          if (!tx_busy) begin
            byte_count <= byte_count + 16'd1;
            if (last_q) begin
              lock   <= 1'b0;
              rr_ptr <= next_id;
              state  <= IDLE;
            end else begin
              cnt   <= '0;
              state <= ACCEPT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets go in, and a monitor checks every tx_start
// against the queue of expected (grant, byte) pairs. A small UART model drives tx_busy.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } src_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic           clk;
  logic           wb_rst_i;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;
  logic           err_clr;
  logic [15:0]    byte_count;

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .BUSY_TIMEOUT(64)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .byte_count  (byte_count)
  );

  src_t src_q [N][$];
  exp_t exp_q[$];
  int   starts[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ready1_cnt = 0;
  bit   uart_dead = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back('{data: d, last: l});
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back('{id: id, data: d});
  endtask

  function automatic bit src_empty();
    bit e;
    e = (req_valid == '0);
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Requester model: holds valid/data/last stable until the handshake, then shows the next entry.
  initial begin
    logic [N-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = src_q[i][0].data;
          req_last[i]         = src_q[i][0].last;
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'h00;
          req_last[i]         = 1'b0;
        end
      end
    end
  end

  // UART model: busy rises two cycles after tx_start and lasts ten cycles, unless the UART is dead.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !uart_dead) begin
        repeat (2) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every start pulse must match the next expected (grant, byte).
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (req_ready[1] === 1'b1) ready1_cnt++;
    if (tx_start === 1'b1) begin
      starts.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_tx_start", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tx_grant", 32'(grant_id), 32'(e.id));
        check("tx_data", 32'(tx_data), 32'(e.data));
      end
    end
  end

  task automatic wait_tx_start(input int budget);
    bit found = 0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (tx_start === 1'b1) found = 1;
    end
    check("wait_tx_start", 32'(found), 32'd1);
  endtask

  task automatic wait_quiet(input int budget);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (busy === 1'b0 && tx_busy === 1'b0 && exp_q.size() == 0 && src_empty()) done = 1;
    end
    check("wait_quiet", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int base;
    wb_rst_i = 1'b1;
    err_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1 wb_rst_i = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);

    // Single byte from requester 1.
    @(negedge clk);
    ready1_cnt = 0;
    t0 = cyc + 1;
    push_src(1, 8'hAB, 1'b1);
    push_exp(2'd1, 8'hAB);
    wait_tx_start(20);
    check("start_latency", 32'(cyc - t0), 32'd2);
    wait_quiet(100);
    check("single_ready_cycles", 32'(ready1_cnt), 32'd1);
    check("single_byte_count", 32'(byte_count), 32'd1);
    check("single_grant_hold", 32'(grant_id), 32'd1);

    // Round robin: pointer is now 2, all four requesters have two 1-byte packets.
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      push_src(i, 8'h10 + 8'(i), 1'b1);
      push_src(i, 8'h20 + 8'(i), 1'b1);
    end
    push_exp(2'd2, 8'h12); push_exp(2'd3, 8'h13); push_exp(2'd0, 8'h10); push_exp(2'd1, 8'h11);
    push_exp(2'd2, 8'h22); push_exp(2'd3, 8'h23); push_exp(2'd0, 8'h20); push_exp(2'd1, 8'h21);
    wait_quiet(400);
    check("rr_byte_count", 32'(byte_count), 32'd9);

    // Packet lock: requester 2 sends three bytes while requester 0 waits.
    @(negedge clk);
    base = starts.size();
    push_src(2, 8'hA0, 1'b0);
    push_src(2, 8'hA1, 1'b0);
    push_src(2, 8'hA2, 1'b1);
    push_src(0, 8'hB0, 1'b1);
    push_exp(2'd2, 8'hA0); push_exp(2'd2, 8'hA1); push_exp(2'd2, 8'hA2); push_exp(2'd0, 8'hB0);
    wait_quiet(300);
    check("lock_gap_1", 32'(starts[base+1] - starts[base]), 32'd14);
    check("lock_gap_2", 32'(starts[base+2] - starts[base+1]), 32'd14);
    check("lock_gap_next_pkt", 32'(starts[base+3] - starts[base+2]), 32'd15);
    check("lock_byte_count", 32'(byte_count), 32'd13);

    // Busy timeout: requester 1, UART never goes busy.
    uart_dead = 1;
    @(negedge clk);
    push_src(1, 8'hC1, 1'b1);
    push_exp(2'd1, 8'hC1);
    wait_tx_start(20);
    repeat (64) @(posedge clk);
    #1;
    check("to_err_before", 32'(timeout_err), 32'd0);
    check("to_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_byte_count", 32'(byte_count), 32'd13);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("to_err_clr", 32'(timeout_err), 32'd0);
    uart_dead = 0;
    @(negedge clk);
    push_src(0, 8'hD0, 1'b1);
    push_src(2, 8'hD2, 1'b1);
    push_exp(2'd2, 8'hD2); push_exp(2'd0, 8'hD0);
    wait_quiet(200);
    check("to_next_byte_count", 32'(byte_count), 32'd15);

    // Second timeout with err_clr on the set cycle: the set must win.
    uart_dead = 1;
    @(negedge clk);
    push_src(3, 8'hE3, 1'b1);
    push_exp(2'd3, 8'hE3);
    wait_tx_start(20);
    repeat (64) @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("set_wins_err", 32'(timeout_err), 32'd1);
    @(posedge clk);
    #1;
    check("err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("err_clr_again", 32'(timeout_err), 32'd0);
    uart_dead = 0;

    // Lock release: requester 1 sends a non-last byte then goes silent.
    @(negedge clk);
    base = starts.size();
    push_src(1, 8'hF1, 1'b0);
    push_exp(2'd1, 8'hF1);
    wait_tx_start(20);
    push_src(0, 8'h50, 1'b1);
    push_src(2, 8'h52, 1'b1);
    push_exp(2'd2, 8'h52); push_exp(2'd0, 8'h50);
    wait_quiet(400);
    check("release_hold_cycles", 32'(starts[base+1] - starts[base]), 32'd79);
    check("release_no_err", 32'(timeout_err), 32'd0);
    check("release_byte_count", 32'(byte_count), 32'd18);

    // Reset while the arbiter is waiting for the frame to finish.
    @(negedge clk);
    push_src(3, 8'h63, 1'b1);
    push_exp(2'd3, 8'h63);
    wait_tx_start(20);
    repeat (5) @(posedge clk);
    #1 wb_rst_i = 1'b1;
    @(posedge clk);
    #1 wb_rst_i = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_byte_count", 32'(byte_count), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    for (int c = 0; c < 20 && tx_busy === 1'b1; c++) @(negedge clk);
    check("midrst_uart_idle", 32'(tx_busy), 32'd0);
    @(negedge clk);
    push_src(3, 8'h73, 1'b1);
    push_src(0, 8'h70, 1'b1);
    push_exp(2'd0, 8'h70); push_exp(2'd3, 8'h73);
    wait_quiet(200);
    check("post_rst_byte_count", 32'(byte_count), 32'd2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
